// File: rtl/conv_window_buffer.sv
// Sliding 3x3 window former: two line buffers plus a 3x3 register array over a raster pixel stream.
// Optional macro CONV_WIN_COUNT_EN adds a per-frame window handshake counter output (win_count).
module conv_window_buffer #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned PIX_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [4:0]         win_row,
    output logic [4:0]         win_col,
`ifdef CONV_WIN_COUNT_EN
    output logic [9:0]         win_count,
`endif
    output logic               frame_done
);

    localparam logic [4:0] ColLast = 5'(IMG_W - 1);
    localparam logic [4:0] RowLast = 5'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e             state_q, state_d;
    logic [4:0]         row_q, row_d, col_q, col_d;
    logic [PIX_W-1:0]   win_q [9];
    logic [PIX_W-1:0]   win_d [9];
    logic               win_valid_q, win_valid_d;
    logic [4:0]         win_row_q, win_row_d, win_col_q, win_col_d;
    logic               frame_done_q, frame_done_d;
    logic [PIX_W-1:0]   line_a_q [IMG_W];
    logic [PIX_W-1:0]   line_b_q [IMG_W];
    logic               accept;

    // A stalled window blocks intake so the window registers never shift under it.
    assign pix_ready = (state_q == StStream) && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StStream;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StStream: begin
                if (accept) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = row_q + 5'd1;
                        if (row_q == RowLast) begin
                            state_d = StFlush;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            StFlush: begin
                if (!win_valid_q || win_ready) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]     = win_q[3*r+1];
                win_d[3*r + 1] = win_q[3*r+2];
            end
            win_d[2] = line_b_q[col_q];
            win_d[5] = line_a_q[col_q];
            win_d[8] = pix_in;
            // Columns 0-1 still hold the previous row's pixels, so they never emit.
            if (row_q >= 5'd2 && col_q >= 5'd2) begin
                win_valid_d = 1'b1;
                win_row_d   = row_q - 5'd2;
                win_col_d   = col_q - 5'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer contents are never observable before being overwritten, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_b_q[col_q] <= line_a_q[col_q];
            line_a_q[col_q] <= pix_in;
        end
    end

`ifdef CONV_WIN_COUNT_EN
    logic [9:0] win_count_q, win_count_d;

    always_comb begin
        win_count_d = win_count_q;
        if (win_valid_q && win_ready) begin
            win_count_d = win_count_q + 10'd1;
        end
        if (state_q == StIdle && frame_start) begin
            win_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_count_q <= '0;
        end else begin
            win_count_q <= win_count_d;
        end
    end

    assign win_count = win_count_q;
`endif

    always_comb begin
        win_out = '0;
        for (int i = 0; i < 9; i++) begin
            win_out[PIX_W*i +: PIX_W] = win_q[i];
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer: window model from pixel coordinates, directed frames.
// Exercises the CONV_WIN_COUNT_EN counter when that macro is defined.
module tb_conv_window_buffer;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int P    = 24;
    localparam int OW   = W - 2;
    localparam int NWIN = (H - 2) * (W - 2);

    logic             clk = 1'b0;
    logic             rst, frame_start, pix_valid, pix_ready;
    logic             win_valid, win_ready, frame_done;
    logic [P-1:0]     pix_in;
    logic [9*P-1:0]   win_out;
    logic [4:0]       win_row, win_col;
`ifdef CONV_WIN_COUNT_EN
    logic [9:0]       win_count;
`endif

    conv_window_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .win_out     (win_out),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_col     (win_col),
`ifdef CONV_WIN_COUNT_EN
        .win_count   (win_count),
`endif
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int win_idx = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    logic [9*P-1:0] first_win, last_win, row1_win, prev_out;
    logic [4:0]     last_row, last_col, prev_row, prev_col;
    logic           prev_stall = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input logic [9*P-1:0] act,
                           input logic [9*P-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pixel at (r,c) carries value r*W+c; a window at (wr,wc) is the 3x3 block starting there.
    function automatic logic [9*P-1:0] model_win(input int wr, input int wc);
        logic [9*P-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[P*(3*r+c) +: P] = P'((wr + r) * W + wc + c);
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(win_valid), 64'd1);
                chk_win("hold_out", win_out, prev_out);
                chk("hold_row", 64'(win_row), 64'(prev_row));
                chk("hold_col", 64'(win_col), 64'(prev_col));
            end
            if (win_valid && !win_ready) chk("stall_pix_ready", 64'(pix_ready), 64'd0);
            if (win_valid && win_ready) begin
                chk("win_row", 64'(win_row), 64'(win_idx / OW));
                chk("win_col", 64'(win_col), 64'(win_idx % OW));
                chk_win("win_out", win_out, model_win(win_idx / OW, win_idx % OW));
                if (win_idx == 0) first_win = win_out;
                if (win_idx == OW) row1_win = win_out;
                last_win    = win_out;
                last_row    = win_row;
                last_col    = win_col;
                last_hs_cyc = cyc;
                win_idx++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_windows", 64'(win_idx), 64'(NWIN));
                chk("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
            end
            prev_stall = win_valid && !win_ready;
            prev_out   = win_out;
            prev_row   = win_row;
            prev_col   = win_col;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_win_valid"}, 64'(win_valid), 64'd0);
        chk_win({tag, "_win_out"}, win_out, '0);
        chk({tag, "_win_row"}, 64'(win_row), 64'd0);
        chk({tag, "_win_col"}, 64'(win_col), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_pix_ready"}, 64'(pix_ready), 64'd0);
`ifdef CONV_WIN_COUNT_EN
        chk({tag, "_win_count"}, 64'(win_count), 64'd0);
`endif
    endtask

    task automatic run_frame(input bit gaps, input bit stall, input int abort_row);
        int  k = 0;
        int  budget = 0;
        int  stall_cnt = 0;
        bit  fs_mid = 1'b0;
        win_idx  = 0;
        done_cnt = 0;
        @(posedge clk); #1;
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        win_ready   = 1'b1;
        while (k < W * H) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (abort_row >= 0 && k == abort_row * W) begin
                rst       = 1'b1;
                pix_valid = 1'b0;
                @(posedge clk); #1;
                check_zero_outputs("abort");
                rst = 1'b0;
                return;
            end
            if (!fs_mid && k == 100) begin
                frame_start = 1'b1;
                fs_mid      = 1'b1;
            end
            if (stall && win_valid && win_row == 5'd3 && win_col == 5'd7 && stall_cnt < 5) begin
                win_ready = 1'b0;
                stall_cnt++;
            end else begin
                win_ready = 1'b1;
            end
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in    = P'(k);
            #1;
            if (pix_valid && pix_ready) k++;
            if (++budget > 20000) begin
                chk("stream_timeout", 64'(k), 64'(W * H));
                return;
            end
        end
        for (int n = 0; n < 50 && done_cnt == 0; n++) begin
            @(posedge clk); #1;
            pix_valid   = 1'b0;
            frame_start = (n == 0);
            win_ready   = (stall && n < 3) ? 1'b0 : 1'b1;
        end
        frame_start = 1'b0;
        win_ready   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("frame_done_count", 64'(done_cnt), 64'd1);
        chk("idle_pix_ready", 64'(pix_ready), 64'd0);
        chk("idle_win_valid", 64'(win_valid), 64'd0);
        chk("window_total", 64'(win_idx), 64'(NWIN));
        chk("stall_cycles", 64'(stall_cnt), stall ? 64'd5 : 64'd0);
`ifdef CONV_WIN_COUNT_EN
        chk("win_count_final", 64'(win_count), 64'd676);
`endif
        chk("first_top_left", 64'(first_win[0 +: P]), 64'd0);
        chk("first_centre", 64'(first_win[P*4 +: P]), 64'd29);
        chk("first_bot_right", 64'(first_win[P*8 +: P]), 64'd58);
        chk("last_row", 64'(last_row), 64'd25);
        chk("last_col", 64'(last_col), 64'd25);
        chk("last_top_left", 64'(last_win[0 +: P]), 64'd725);
        chk("last_bot_right", 64'(last_win[P*8 +: P]), 64'd783);
        chk("row1_c0_top", 64'(row1_win[0 +: P]), 64'd28);
        chk("row1_c0_bot", 64'(row1_win[P*6 +: P]), 64'd84);
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_in      = '0;
        win_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        run_frame(1'b0, 1'b0, -1);
        run_frame(1'b0, 1'b1, -1);
        run_frame(1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b0, 10);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_idle_ready", 64'(pix_ready), 64'd0);
        run_frame(1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
